mem_dump_scanner: RTL and testbench
===================================

MEM_DUMP_SCANNER -- requirements
Module: mem_dump_scanner

Interface
REQ-001 The block SHALL have parameter DB_CYC, default 500000, setting the debounce stable-time in cycles (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter DWELL_CYC, default 50000000, setting the autoscan dwell per word in cycles.
REQ-003 Port CLK: input, 1 bit, the single clock, rising-edge; all state in this block is clocked by CLK.
REQ-004 Port nRST: input, 1 bit; reset is asynchronous and active-low.
REQ-005 Port halt: input, 1 bit, the system halt flag.
REQ-006 Port key_step_n: input, 1 bit, raw asynchronous pushbutton, active-low.
REQ-007 Port sw_addr: input, 16 bits, switch-selected byte address.
REQ-008 Port load: input, 32 bits, memory read data from the system.
REQ-009 Port REN: output, 1 bit, memory read request to the system.
REQ-010 Port addr: output, 32 bits, memory read address, {16'b0, ptr}.
REQ-011 Port disp_word: output, 32 bits, captured word for the hex display.
REQ-012 Port disp_addr: output, 16 bits, address of disp_word.
REQ-013 Port busy: output, 1 bit, high while a read is in flight.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, READ, CAPTURE and SHOW.
REQ-015 IDLE: REN=0, busy=0 and ptr tracks sw_addr every cycle; halt=1 → READ.
REQ-016 READ: REN=1, busy=1, addr={16'b0,ptr}; next cycle → CAPTURE.
REQ-017 CAPTURE: REN=1, busy=1; disp_word<=load and disp_addr<=ptr at this clock edge; → SHOW.
REQ-018 Read latency SHALL be exactly 2 cycles from entering READ to disp_word being updated.
REQ-019 SHOW: REN=1, busy=0, addr holds ptr.
REQ-020 In SHOW, a registered sw_addr differing from ptr SHALL load ptr<=sw_addr and go → READ.
REQ-021 In SHOW, a debounced step pulse SHALL set ptr<=ptr+4 and go → READ.
REQ-022 If a switch change and a step pulse occur in the same cycle, the switch change SHALL win and the step SHALL be dropped.
REQ-023 The pointer increment SHALL be 16-bit modular: 16'hFFFC+4 → 16'h0000; ptr[1:0] is forced to 2'b00 on every load.
REQ-024 halt=0 in any state SHALL go → IDLE next cycle; a read in flight is abandoned and disp_word keeps its last value.
REQ-025 Step pulses in READ or CAPTURE SHALL be ignored, not queued.
REQ-026 The debouncer SHALL synchronise key_step_n with 2 flip-flops.
REQ-027 The debouncer SHALL emit one 1-cycle pulse after the input has been low continuously for DB_CYC cycles.
REQ-028 After a pulse, the debouncer SHALL re-arm only after the input has been high continuously for DB_CYC cycles; glitches shorter than DB_CYC produce no pulse.

Reset
REQ-029 On nRST=0, at any time including mid-read, the FSM SHALL enter IDLE.
REQ-030 On nRST=0, ptr, disp_word, disp_addr, REN, busy, the dwell counter and the debouncer state SHALL all go to 0 (addr=0).
REQ-031 On nRST=0, the synchroniser flops SHALL reset to 1 (key released).

Configuration
REQ-032 Macro MEM_DUMP_AUTOSCAN_EN defined: in SHOW, a dwell counter counts to DWELL_CYC-1 and then acts as a step pulse.
REQ-033 With the macro defined, the dwell counter SHALL clear on entry to SHOW, on a manual step and on a switch change; a manual step has priority over the dwell expiry.
REQ-034 Macro MEM_DUMP_AUTOSCAN_EN undefined: no dwell counter SHALL exist and only manual steps advance ptr.

Structure
REQ-035 Package mem_dump_pkg SHALL hold the state enum scan_state_t (IDLE, READ, CAPTURE, SHOW) and the constant WORD_BYTES=4.
REQ-036 Sub-module key_debounce (ports CLK, nRST, key_n, press) SHALL hold the synchroniser, the stability counter and the re-arm logic.

Verification (DB_CYC=4, DWELL_CYC=8)
REQ-037 Reset asserted mid-CAPTURE → the next cycle shows state IDLE, REN=0, disp_word=0, busy=0.
REQ-038 sw_addr=16'h0040, halt rises, load returns 32'hDEADBEEF → disp_word=DEADBEEF and disp_addr=0040 exactly 2 cycles after READ entry.
REQ-039 In SHOW at ptr=16'hFFFC, key held low for 6 cycles → exactly one read at addr 0x00000000.
REQ-040 A 3-cycle low glitch on key_step_n → no step and ptr unchanged.
REQ-041 Step pulse and sw_addr change to 16'h0100 in the same cycle → the next read is at 0x100, not ptr+4.
REQ-042 With MEM_DUMP_AUTOSCAN_EN, SHOW at 16'h0010 and no key activity → reads at 0x14 and then 0x18, each 8 cycles of SHOW apart; halt falling → IDLE and REN=0.

Source files
------------

// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory dump scanner.
package mem_dump_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        SHOW    = 2'd3
    } scan_state_t;

    localparam logic [15:0] WORD_BYTES = 16'd4;

    function automatic logic [15:0] word_align(input logic [15:0] a);
        return {a[15:2], 2'b00};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter, one pulse per
// press, re-armed only after a stable release of the same length.
module key_debounce #(
    parameter int DB_CYC = 500000
) (
    input  logic CLK,
    input  logic nRST,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    logic          sync1;
    logic          sync2;
    logic          latched;
    logic [CW-1:0] cnt;
    logic          at_target;

    // While armed we wait for a stable low; once fired we wait for a stable high.
    assign at_target = latched ? sync2 : ~sync2;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            latched <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (!at_target) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYC - 1)) begin
                cnt     <= '0;
                latched <= ~latched;
                press   <= ~latched;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_dump_scanner.sv
// Halt-time memory dump scanner: reads the word at a switch-selected address and
// steps through memory on a debounced key. MEM_DUMP_AUTOSCAN_EN adds a dwell timer.
module mem_dump_scanner
    import mem_dump_pkg::*;
#(
    parameter int DB_CYC    = 500000,
    parameter int DWELL_CYC = 50000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        key_step_n,
    input  logic [15:0] sw_addr,
    input  logic [31:0] load,
    output logic        REN,
    output logic [31:0] addr,
    output logic [31:0] disp_word,
    output logic [15:0] disp_addr,
    output logic        busy,
    output scan_state_t dbg_state
);

    scan_state_t state;
    logic [15:0] ptr;
    logic [15:0] sw_q;
    logic [15:0] sw_seen;
    logic        press;
    logic        sw_chg;
    logic        step;

    key_debounce #(.DB_CYC(DB_CYC)) u_key (
        .CLK   (CLK),
        .nRST  (nRST),
        .key_n (key_step_n),
        .press (press)
    );

    // A switch change is a registered value the FSM has not yet acted on.
    assign sw_chg = (sw_q != sw_seen);

`ifdef MEM_DUMP_AUTOSCAN_EN
    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    logic [DW-1:0] dwell_cnt;
    logic          dwell_done;

    assign dwell_done = (dwell_cnt == DW'(DWELL_CYC - 1));
    assign step       = press | dwell_done;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dwell_cnt <= '0;
        end else if (state == SHOW && halt && !sw_chg && !press && !dwell_done) begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end else begin
            dwell_cnt <= '0;
        end
    end
`else
    assign step = press & (DWELL_CYC > 0);
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            ptr       <= '0;
            sw_q      <= '0;
            sw_seen   <= '0;
            disp_word <= '0;
            disp_addr <= '0;
            REN       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sw_q <= sw_addr;
            if (state == IDLE) begin
                ptr     <= word_align(sw_addr);
                sw_seen <= sw_addr;
            end
            if (!halt) begin
                state <= IDLE;
                REN   <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= READ;
                        REN   <= 1'b1;
                        busy  <= 1'b1;
                    end
                    READ: begin
                        state <= CAPTURE;
                    end
                    CAPTURE: begin
                        disp_word <= load;
                        disp_addr <= ptr;
                        busy      <= 1'b0;
                        state     <= SHOW;
                    end
                    SHOW: begin
                        // Switch change outranks a step arriving in the same cycle.
                        if (sw_chg) begin
                            ptr     <= word_align(sw_q);
                            sw_seen <= sw_q;
                            busy    <= 1'b1;
                            state   <= READ;
                        end else if (step) begin
                            ptr   <= ptr + WORD_BYTES;
                            busy  <= 1'b1;
                            state <= READ;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        REN   <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign addr      = {16'h0000, ptr};
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_dump_scanner.sv
// Directed scoreboard bench for mem_dump_scanner (DB_CYC=4, DWELL_CYC=8).
// Build with MEM_DUMP_AUTOSCAN_EN defined to exercise the dwell-timer path.
module tb_mem_dump_scanner;
    import mem_dump_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        halt;
    logic        key_step_n;
    logic [15:0] sw_addr;
    logic [31:0] load;
    logic        REN;
    logic [31:0] addr;
    logic [31:0] disp_word;
    logic [15:0] disp_addr;
    logic        busy;
    scan_state_t dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic        mon_en   = 1'b0;
    logic        busy_d   = 1'b0;
    logic [15:0] ea;
    int          n_show;

    mem_dump_scanner #(.DB_CYC(4), .DWELL_CYC(8)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .halt       (halt),
        .key_step_n (key_step_n),
        .sw_addr    (sw_addr),
        .load       (load),
        .REN        (REN),
        .addr       (addr),
        .disp_word  (disp_word),
        .disp_addr  (disp_addr),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog
    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model: one marker word, every other address returns {~a, a}.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h0040) return 32'hDEADBEEF;
        return {~a, a};
    endfunction

    always_comb load = mem_word(addr[15:0]);

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Driver tasks
    task automatic wait_state(input scan_state_t s, input int budget, input string tag);
        int n = 0;
        while (dbg_state != s && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check({"wait_", tag}, 32'(dbg_state), 32'(s));
    endtask

    task automatic key_low(input int cycles);
        key_step_n = 1'b0;
        repeat (cycles) @(negedge CLK);
        key_step_n = 1'b1;
    endtask

    task automatic count_show(output int n);
        n = 0;
        while (dbg_state == SHOW && n < 50) begin
            n++;
            @(negedge CLK);
        end
    endtask

    // Scoreboard monitor: each new read is matched against the expected queue,
    // then the captured word is checked exactly two cycles after READ entry.
    always begin
        @(negedge CLK);
        if (mon_en && busy && !busy_d) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read_addr", addr, 32'hFFFFFFFF);
            end else begin
                ea = exp_q.pop_front();
                check("read_addr", addr, {16'h0000, ea});
                check("read_ren", 32'(REN), 32'd1);
                @(posedge CLK);
                @(posedge CLK);
                @(negedge CLK);
                check("disp_word", disp_word, mem_word(ea));
                check("disp_addr", 32'(disp_addr), 32'(ea));
            end
        end
        busy_d = busy;
    end

    initial begin
        nRST       = 1'b0;
        halt       = 1'b0;
        key_step_n = 1'b1;
        sw_addr    = 16'h0020;
        repeat (3) @(negedge CLK);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_ren", 32'(REN), 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_disp_word", disp_word, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        // Reset asserted mid-CAPTURE
        halt = 1'b1;
        wait_state(CAPTURE, 10, "capture_pre_reset");
        nRST = 1'b0;
        @(negedge CLK);
        check("midread_rst_state", 32'(dbg_state), 32'(IDLE));
        check("midread_rst_ren", 32'(REN), 32'd0);
        check("midread_rst_busy", 32'(busy), 32'd0);
        check("midread_rst_disp_word", disp_word, 32'd0);
        halt = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // First read at 0x0040
        mon_en  = 1'b1;
        sw_addr = 16'h0040;
        @(negedge CLK);
        exp_q.push_back(16'h0040);
        halt = 1'b1;
        @(negedge CLK);
        wait_state(SHOW, 10, "show_0040");

`ifndef MEM_DUMP_AUTOSCAN_EN
        // Short glitch must not step
        key_low(3);
        repeat (15) @(negedge CLK);
        check("glitch_state", 32'(dbg_state), 32'(SHOW));
        check("glitch_addr", addr, 32'h0000_0040);

        // Switch to the top word, then step across the 16-bit wrap
        exp_q.push_back(16'hFFFC);
        sw_addr = 16'hFFFC;
        repeat (3) @(negedge CLK);
        wait_state(SHOW, 10, "show_fffc");
        exp_q.push_back(16'h0000);
        key_low(6);
        repeat (25) @(negedge CLK);
        check("wrap_state", 32'(dbg_state), 32'(SHOW));
        check("wrap_addr", addr, 32'h0000_0000);

        // Step pulse and switch change land on the same cycle: switch wins
        exp_q.push_back(16'h0100);
        key_step_n = 1'b0;
        repeat (5) @(negedge CLK);
        sw_addr = 16'h0100;
        @(negedge CLK);
        key_step_n = 1'b1;
        repeat (30) @(negedge CLK);
        check("tie_state", 32'(dbg_state), 32'(SHOW));
        check("tie_addr", addr, 32'h0000_0100);

        // Halt falling returns to IDLE, display keeps its word
        halt = 1'b0;
        @(negedge CLK);
        check("unhalt_state", 32'(dbg_state), 32'(IDLE));
        check("unhalt_ren", 32'(REN), 32'd0);
        check("unhalt_busy", 32'(busy), 32'd0);
        check("unhalt_disp_word", disp_word, 32'hFEFF_0100);
`else
        halt = 1'b0;
        @(negedge CLK);
        check("unhalt_state", 32'(dbg_state), 32'(IDLE));
        sw_addr = 16'h0010;
        @(negedge CLK);
        exp_q.push_back(16'h0010);
        exp_q.push_back(16'h0014);
        exp_q.push_back(16'h0018);
        halt = 1'b1;
        @(negedge CLK);
        wait_state(SHOW, 10, "show_0010");
        count_show(n_show);
        check("dwell_0010", 32'(n_show), 32'd8);
        wait_state(SHOW, 10, "show_0014");
        count_show(n_show);
        check("dwell_0014", 32'(n_show), 32'd8);
        wait_state(SHOW, 10, "show_0018");
        check("auto_addr_0018", addr, 32'h0000_0018);
        halt = 1'b0;
        @(negedge CLK);
        check("auto_unhalt_state", 32'(dbg_state), 32'(IDLE));
        check("auto_unhalt_ren", 32'(REN), 32'd0);
`endif

        repeat (5) @(negedge CLK);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
